// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_driver
//  Description : Multiplexed seven-segment scanner. Captures one of CHANNELS
//                hex words into a shadow register and time-multiplexes its
//                DIGITS nibbles onto active-low anode/segment pins, with
//                leading-zero blanking, per-digit decimal points, enable
//                gating and a frame-done strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int DIGITS   = 8,
    parameter int CHANNELS = 4,
    parameter int DIV      = 100000,
    localparam int c_sel_w = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS*4*DIGITS-1:0]   data_in,
    input  logic [c_sel_w-1:0]             sel,
    input  logic [DIGITS-1:0]              dp_in,
    input  logic                           load,
    input  logic                           blank_lz,
    input  logic                           enable,
    output logic [DIGITS-1:0]              AN,
    output logic [7:0]                     SEG,
    output logic                           frame_done
);

    localparam int c_word_w  = 4 * DIGITS;
    localparam int c_idx_w   = $clog2(DIGITS);
    localparam int c_presc_w = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [c_presc_w-1:0] c_presc_last = c_presc_w'(DIV - 1);
    localparam logic [c_idx_w-1:0]   c_idx_last   = c_idx_w'(DIGITS - 1);
    localparam logic [DIGITS-1:0]    c_an_one     = DIGITS'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_presc_w-1:0] r_presc;
    logic [c_idx_w-1:0]   r_idx;
    logic [c_word_w-1:0]  r_shadow;
    logic [DIGITS-1:0]    r_dp;
    logic [DIGITS-1:0]    r_an;
    logic [7:0]           r_seg;
    logic                 r_frame_done;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic                 w_tick;
    logic [c_word_w-1:0]  w_word;
    logic [3:0]           w_nibs [DIGITS];
    logic [DIGITS-1:0]    w_zero;
    logic [DIGITS-1:0]    w_lead;
    logic [3:0]           w_nib;
    logic [6:0]           w_hex;
    logic                 w_blank;
    logic [DIGITS-1:0]    w_an;

    // Slot advance happens in the last prescaler count of each slot; frozen when disabled.
    assign w_tick = enable && (r_presc == c_presc_last);

    // Channel select; any select value without a matching channel falls back to channel 0.
    always_comb begin
        w_word = data_in[0 +: c_word_w];
        for (int c = 1; c < CHANNELS; c++) begin
            if (sel == c_sel_w'(c)) begin
                w_word = data_in[c*c_word_w +: c_word_w];
            end
        end
    end

    // Split the shadow word into nibbles and flag the zero ones.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
        assign w_nibs[gi] = r_shadow[gi*4 +: 4];
        assign w_zero[gi] = (r_shadow[gi*4 +: 4] == 4'h0);
    end

    // w_lead[i] is set when nibbles DIGITS-1 down to i are all zero.
    assign w_lead[DIGITS-1] = w_zero[DIGITS-1];
    for (genvar gi = 0; gi < DIGITS - 1; gi++) begin : g_lead
        assign w_lead[gi] = w_zero[gi] & w_lead[gi+1];
    end

    assign w_nib = w_nibs[r_idx];

    // Digit 0 is never blanked so that a zero value still shows one "0".
    assign w_blank = blank_lz && (r_idx != '0) && w_lead[r_idx];

    // Only the current slot's anode is pulled low.
    assign w_an = ~(c_an_one << r_idx);

    // Hex to active-low {g,f,e,d,c,b,a} decode.
    always_comb begin
        w_hex = 7'h7F;
        case (w_nib)
            4'h0:    w_hex = 7'h40;
            4'h1:    w_hex = 7'h79;
            4'h2:    w_hex = 7'h24;
            4'h3:    w_hex = 7'h30;
            4'h4:    w_hex = 7'h19;
            4'h5:    w_hex = 7'h12;
            4'h6:    w_hex = 7'h02;
            4'h7:    w_hex = 7'h78;
            4'h8:    w_hex = 7'h00;
            4'h9:    w_hex = 7'h10;
            4'hA:    w_hex = 7'h08;
            4'hB:    w_hex = 7'h03;
            4'hC:    w_hex = 7'h46;
            4'hD:    w_hex = 7'h21;
            4'hE:    w_hex = 7'h06;
            default: w_hex = 7'h0E;
        endcase
    end

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // Prescaler and digit index; both hold while disabled so the scan resumes in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc <= '0;
            r_idx   <= '0;
        end else if (enable) begin
            if (w_tick) begin
                r_presc <= '0;
                r_idx   <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc + 1'b1;
            end
        end
    end

    // Shadow capture on load, independent of enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
            r_dp     <= '0;
        end else if (load) begin
            r_shadow <= w_word;
            r_dp     <= dp_in;
        end
    end

    // Registered pin drive and frame strobe, one cycle behind the scan state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_an         <= '1;
            r_seg        <= 8'hFF;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_tick && (r_idx == c_idx_last);
            if (!enable || w_blank) begin
                r_an  <= '1;
                r_seg <= 8'hFF;
            end else begin
                r_an  <= w_an;
                r_seg <= {~r_dp[r_idx], w_hex};
            end
        end
    end

    assign AN         = r_an;
    assign SEG        = r_seg;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_driver
//  Description : Directed self-checking bench for seg_scan_driver. One
//                instance uses DIV=4 / CHANNELS=2, a second uses DIV=1 /
//                CHANNELS=3 for per-cycle scanning and out-of-range select.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    logic        clk;
    logic        rst;
    logic [63:0] data_in;
    logic        sel;
    logic [95:0] data_in1;
    logic [1:0]  sel1;
    logic [7:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic        enable;
    logic [7:0]  an0, seg0, an1, seg1;
    logic        fd0, fd1;

    int checks = 0;
    int errors = 0;
    int fd_cnt;

    logic [7:0] exp_an  [8];
    logic [7:0] exp_seg [8];

    seg_scan_driver #(.DIGITS(8), .CHANNELS(2), .DIV(4)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .sel(sel), .dp_in(dp_in),
        .load(load), .blank_lz(blank_lz), .enable(enable),
        .AN(an0), .SEG(seg0), .frame_done(fd0)
    );

    seg_scan_driver #(.DIGITS(8), .CHANNELS(3), .DIV(1)) dut1 (
        .clk(clk), .rst(rst), .data_in(data_in1), .sel(sel1), .dp_in(dp_in),
        .load(load), .blank_lz(blank_lz), .enable(enable),
        .AN(an1), .SEG(seg1), .frame_done(fd1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // At most one anode low on either instance, every cycle out of reset.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            assert ($countones(~an0) <= 1 && $countones(~an1) <= 1) else begin
                errors++;
                $error("FAIL an_onehot: observed an0=%h an1=%h expected at most one low bit", an0, an1);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset between edges, then load on the next edge so the frame starts aligned.
    task automatic sync_load(input logic [63:0] d, input logic s, input logic [7:0] dp);
        rst = 1'b1;
        #1;
        rst     = 1'b0;
        data_in = d;
        sel     = s;
        dp_in   = dp;
        load    = 1'b1;
        step();
        load    = 1'b0;
    endtask

    // Walk edges 2..33 of a freshly synced frame on the DIV=4 instance.
    task automatic run_frame(input string tag);
        for (int e = 2; e <= 33; e++) begin
            step();
            if (e % 4 == 2) begin
                chk({tag, "_an"},  {24'h0, an0},  {24'h0, exp_an[(e-2)/4]});
                chk({tag, "_seg"}, {24'h0, seg0}, {24'h0, exp_seg[(e-2)/4]});
            end
            if (e >= 31) chk({tag, "_fd"}, {31'h0, fd0}, (e == 32) ? 32'd1 : 32'd0);
        end
    endtask

    initial begin
        rst = 1'b0; data_in = '0; sel = 1'b0; data_in1 = '0; sel1 = 2'd0;
        dp_in = '0; load = 1'b0; blank_lz = 1'b0; enable = 1'b1;
        exp_an = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_an",  {24'h0, an0},  32'hFF);
        chk("rst_seg", {24'h0, seg0}, 32'hFF);
        chk("rst_fd",  {31'h0, fd0},  32'h0);
        step();
        rst = 1'b0;

        // Full frame of 1234ABCD on channel 1, no blanking
        exp_seg = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        sync_load({32'h1234ABCD, 32'h0}, 1'b1, 8'h00);
        run_frame("t2");
        fd_cnt = 0;
        for (int e = 34; e <= 65; e++) begin
            step();
            if (fd0) fd_cnt++;
        end
        chk("t2_fd_per_frame", fd_cnt, 32'd1);

        // Mid-frame reset at slot 5
        for (int i = 0; i < 21; i++) step();
        chk("t1_pre_an",  {24'h0, an0},  32'hDF);
        chk("t1_pre_seg", {24'h0, seg0}, 32'hB0);
        #2 rst = 1'b1;
        #1;
        chk("t1_async_an",  {24'h0, an0},  32'hFF);
        chk("t1_async_seg", {24'h0, seg0}, 32'hFF);
        rst = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            step();
            if (e == 4) begin
                chk("t1_e4_an",  {24'h0, an0},  32'hFE);
                chk("t1_e4_seg", {24'h0, seg0}, 32'hC0);
            end
            if (e == 5) chk("t1_e5_an", {24'h0, an0}, 32'hFD);
        end

        // Leading-zero blanking of 000000A0
        blank_lz = 1'b1;
        exp_an  = '{8'hFE, 8'hFD, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        exp_seg = '{8'hC0, 8'h88, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        sync_load({32'h000000A0, 32'h0}, 1'b1, 8'h00);
        run_frame("t3a");

        // Value zero with blanking shows a single 0
        exp_an  = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        exp_seg = '{8'hC0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        sync_load({32'h1234ABCD, 32'h0}, 1'b0, 8'h00);
        run_frame("t3b");

        // Decimal point on slot 2 of a zero channel 0
        blank_lz = 1'b0;
        exp_an  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
        exp_seg = '{8'hC0, 8'hC0, 8'h40, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
        sync_load({32'h1234ABCD, 32'h0}, 1'b0, 8'h04);
        run_frame("t4");

        // Disable for 10 cycles while at slot 3, then resume in place
        sync_load({32'h1234ABCD, 32'h0}, 1'b1, 8'h00);
        for (int e = 2; e <= 13; e++) step();
        chk("t5_pre_an", {24'h0, an0}, 32'hF7);
        enable = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 1 || i == 10) begin
                chk("t5_dark_an",  {24'h0, an0},  32'hFF);
                chk("t5_dark_seg", {24'h0, seg0}, 32'hFF);
            end
        end
        enable = 1'b1;
        step();
        chk("t5_f1_an",  {24'h0, an0},  32'hF7);
        chk("t5_f1_seg", {24'h0, seg0}, 32'h88);
        step();
        step();
        chk("t5_f3_an",  {24'h0, an0},  32'hF7);
        step();
        chk("t5_f4_an",  {24'h0, an0},  32'hEF);
        chk("t5_f4_seg", {24'h0, seg0}, 32'h99);

        // DIV=1 instance: every edge advances the slot
        data_in1 = {32'hFFFFFFFF, 32'h76543210, 32'h00000005};
        sel1     = 2'd1;
        exp_seg  = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8};
        sync_load(64'h0, 1'b0, 8'h00);
        for (int e = 2; e <= 9; e++) begin
            step();
            chk("t6_an",  {24'h0, an1},  {24'h0, exp_an[(e-1)%8]});
            chk("t6_seg", {24'h0, seg1}, {24'h0, exp_seg[(e-1)%8]});
            if (e == 7 || e == 8) chk("t6_fd", {31'h0, fd1}, (e == 8) ? 32'd1 : 32'd0);
        end
        // Load coincides with a tick
        data_in1 = {32'hFFFFFFFF, 32'hFEDCBA98, 32'h00000005};
        load = 1'b1;
        step();
        load = 1'b0;
        chk("t6_old_an",  {24'h0, an1},  32'hFD);
        chk("t6_old_seg", {24'h0, seg1}, 32'hF9);
        step();
        chk("t6_new_an",  {24'h0, an1},  32'hFB);
        chk("t6_new_seg", {24'h0, seg1}, 32'h88);
        step();
        chk("t6_next_seg", {24'h0, seg1}, 32'h83);

        // Out-of-range select captures channel 0, with dp on slot 2
        data_in1 = {32'hFFFFFFFF, 32'h76543210, 32'h00000005};
        sel1     = 2'd3;
        sync_load(64'h0, 1'b0, 8'h04);
        step();
        chk("t4r_e2_an",  {24'h0, an1},  32'hFD);
        chk("t4r_e2_seg", {24'h0, seg1}, 32'hC0);
        step();
        chk("t4r_e3_an",  {24'h0, an1},  32'hFB);
        chk("t4r_e3_seg", {24'h0, seg1}, 32'h40);
        for (int e = 4; e <= 9; e++) step();
        chk("t4r_e9_an",  {24'h0, an1},  32'hFE);
        chk("t4r_e9_seg", {24'h0, seg1}, 32'h92);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
